// File: rtl/ysyx_22050710_axil_slave_wrap_pkg.sv
// rtl/ysyx_22050710_axil_slave_wrap_pkg.sv - response codes and helpers shared by the AXI-lite slave wrapper
//
// Holds the YSYX_22050710_AXI_RESP_* macros and their typed equivalents.
// The macros are guarded so that another file defining the same codes does not clash.

`ifndef YSYX_22050710_AXI_RESP_OKAY
`define YSYX_22050710_AXI_RESP_OKAY   2'b00
`endif
`ifndef YSYX_22050710_AXI_RESP_EXOKAY
`define YSYX_22050710_AXI_RESP_EXOKAY 2'b01
`endif
`ifndef YSYX_22050710_AXI_RESP_SLVERR
`define YSYX_22050710_AXI_RESP_SLVERR 2'b10
`endif
`ifndef YSYX_22050710_AXI_RESP_DECERR
`define YSYX_22050710_AXI_RESP_DECERR 2'b11
`endif

package ysyx_22050710_axil_slave_wrap_pkg;

    localparam logic [1:0] RESP_OKAY   = `YSYX_22050710_AXI_RESP_OKAY;
    localparam logic [1:0] RESP_EXOKAY = `YSYX_22050710_AXI_RESP_EXOKAY;
    localparam logic [1:0] RESP_SLVERR = `YSYX_22050710_AXI_RESP_SLVERR;
    localparam logic [1:0] RESP_DECERR = `YSYX_22050710_AXI_RESP_DECERR;

    // Addresses outside the decoded window never reach memory; they answer DECERR.
    function automatic logic [1:0] resp_for_hit(input logic hit);
        return hit ? RESP_OKAY : RESP_DECERR;
    endfunction

endpackage

// File: rtl/ysyx_22050710_axil_chan_buf.sv
// rtl/ysyx_22050710_axil_chan_buf.sv - single-entry valid/ready holding register for one AXI-lite channel
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   valid, ready    upstream handshake; ready = !full and low during reset
//   payload         data captured on valid & ready
//   clear           empties the entry (takes priority over a load)
//   full, held      occupancy flag and captured payload

module ysyx_22050710_axil_chan_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    output logic             ready,
    input  logic [WIDTH-1:0] payload,
    input  logic             clear,
    output logic             full,
    output logic [WIDTH-1:0] held
);

    assign ready = !full && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            held <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (valid && ready) begin
            full <= 1'b1;
            held <= payload;
        end
    end

endmodule

// File: rtl/ysyx_22050710_axil_slave_wrap.sv
// rtl/ysyx_22050710_axil_slave_wrap.sv - AXI-lite slave that serialises reads and writes onto one req/gnt memory port
//
// Ports:
//   i_aclk, i_arst                  clock, synchronous active-high reset
//   AW/W/B (i_aw*, i_w*, o_b*)      AXI-lite write channels; awprot ignored
//   AR/R   (i_ar*, o_r*)            AXI-lite read channels; arprot ignored
//   o_mem_req/we/addr/wdata/wstrb   memory request, held until i_mem_gnt
//   i_mem_gnt, i_mem_rvalid/rdata   grant and read return (rvalid >= 1 cycle after gnt)

module ysyx_22050710_axil_slave_wrap
    import ysyx_22050710_axil_slave_wrap_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN  = 32'h0800_0000
) (
    input  logic                  i_aclk,
    input  logic                  i_arst,

    input  logic                  i_awvalid,
    output logic                  o_awready,
    input  logic [ADDR_WIDTH-1:0] i_awaddr,
    input  logic [2:0]            i_awprot,

    input  logic                  i_wvalid,
    output logic                  o_wready,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [STRB_WIDTH-1:0] i_wstrb,

    output logic                  o_bvalid,
    input  logic                  i_bready,
    output logic [1:0]            o_bresp,

    input  logic                  i_arvalid,
    output logic                  o_arready,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    input  logic [2:0]            i_arprot,

    output logic                  o_rvalid,
    input  logic                  i_rready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [1:0]            o_rresp,

    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [STRB_WIDTH-1:0] o_mem_wstrb,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        RD_RESP = 3'd3,
        WR_REQ  = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    localparam int WBUF_WIDTH = DATA_WIDTH + STRB_WIDTH;

    state_t                  state;
    state_t                  state_next;

    logic                    aw_full;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic                    w_full;
    logic [WBUF_WIDTH-1:0]   w_held;

    logic                    last_rd;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;
    logic [1:0]              bresp_q;

    logic                    idle;
    logic                    wr_pend;
    logic                    pick_rd;
    logic                    ar_fire;
    logic                    wr_go;
    logic                    b_fire;
    logic                    ar_hit;
    logic                    aw_hit;

    logic                    unused_prot;
    assign unused_prot = ^{i_awprot, i_arprot};

    // Window test is done one bit wider than the address so BASE+SPAN cannot wrap.
    function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] lo;
        logic [ADDR_WIDTH:0] hi;
        logic [ADDR_WIDTH:0] x;
        lo = {1'b0, BASE_ADDR};
        hi = lo + {1'b0, ADDR_SPAN};
        x  = {1'b0, addr};
        return (x >= lo) && (x < hi);
    endfunction

    // ------------------------------------------------------------------
    // Write address / data holding registers. Both stay full until the B
    // response is accepted, which blocks any new write in the meantime.
    // ------------------------------------------------------------------
    ysyx_22050710_axil_chan_buf #(
        .WIDTH (ADDR_WIDTH)
    ) u_aw_buf (
        .clk     (i_aclk),
        .rst     (i_arst),
        .valid   (i_awvalid),
        .ready   (o_awready),
        .payload (i_awaddr),
        .clear   (b_fire),
        .full    (aw_full),
        .held    (aw_addr)
    );

    ysyx_22050710_axil_chan_buf #(
        .WIDTH (WBUF_WIDTH)
    ) u_w_buf (
        .clk     (i_aclk),
        .rst     (i_arst),
        .valid   (i_wvalid),
        .ready   (o_wready),
        .payload ({i_wstrb, i_wdata}),
        .clear   (b_fire),
        .full    (w_full),
        .held    (w_held)
    );

    // ------------------------------------------------------------------
    // Arbitration. The read side gets the port unless a complete write is
    // waiting and the previous grant already went to a read; last_rd thus
    // alternates grants under contention. arready depends on registers only.
    // ------------------------------------------------------------------
    assign idle      = (state == IDLE);
    assign wr_pend   = aw_full && w_full;
    assign pick_rd   = !wr_pend || !last_rd;
    assign o_arready = !i_arst && idle && pick_rd;
    assign ar_fire   = i_arvalid && o_arready;
    assign wr_go     = idle && wr_pend && !(i_arvalid && pick_rd);
    assign b_fire    = o_bvalid && i_bready;

    assign ar_hit    = in_window(i_araddr);
    assign aw_hit    = in_window(aw_addr);

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_aclk) begin
        if (i_arst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_mem_req  = 1'b0;
        o_mem_we   = 1'b0;
        o_rvalid   = 1'b0;
        o_bvalid   = 1'b0;
        case (state)
            IDLE: begin
                if (ar_fire) begin
                    state_next = ar_hit ? RD_REQ : RD_RESP;
                end else if (wr_go) begin
                    state_next = aw_hit ? WR_REQ : WR_RESP;
                end
            end
            RD_REQ: begin
                o_mem_req = 1'b1;
                if (i_mem_gnt) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (i_mem_rvalid) begin
                    state_next = RD_RESP;
                end
            end
            RD_RESP: begin
                o_rvalid = 1'b1;
                if (i_rready) begin
                    state_next = IDLE;
                end
            end
            WR_REQ: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
                if (i_mem_gnt) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                o_bvalid = 1'b1;
                if (i_bready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-transaction registers. A decode miss loads its DECERR response at
    // grant time so the response state can be entered without a memory access.
    // ------------------------------------------------------------------
    always_ff @(posedge i_aclk) begin
        if (i_arst) begin
            last_rd <= 1'b0;
            rd_addr <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            bresp_q <= RESP_OKAY;
        end else begin
            if (ar_fire) begin
                last_rd <= 1'b1;
                rd_addr <= i_araddr;
                if (!ar_hit) begin
                    rdata_q <= '0;
                    rresp_q <= RESP_DECERR;
                end
            end else if (wr_go) begin
                last_rd <= 1'b0;
                bresp_q <= resp_for_hit(aw_hit);
            end

            // Read data is only accepted while waiting for it, so a stale
            // return from before a reset cannot be mistaken for a new one.
            if (state == RD_WAIT && i_mem_rvalid) begin
                rdata_q <= i_mem_rdata;
                rresp_q <= RESP_OKAY;
            end
        end
    end

    assign o_rdata     = rdata_q;
    assign o_rresp     = rresp_q;
    assign o_bresp     = bresp_q;

    assign o_mem_addr  = (state == WR_REQ) ? aw_addr : rd_addr;
    assign o_mem_wdata = w_held[DATA_WIDTH-1:0];
    assign o_mem_wstrb = w_held[DATA_WIDTH +: STRB_WIDTH];

endmodule

// File: tb/tb_ysyx_22050710_axil_slave_wrap.sv
// tb/tb_ysyx_22050710_axil_slave_wrap.sv - scoreboard bench for the AXI-lite slave wrapper

module tb_ysyx_22050710_axil_slave_wrap;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int SW = 8;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_arst;
    logic          i_awvalid, o_awready;
    logic [AW-1:0] i_awaddr;
    logic [2:0]    i_awprot, i_arprot;
    logic          i_wvalid, o_wready;
    logic [DW-1:0] i_wdata;
    logic [SW-1:0] i_wstrb;
    logic          o_bvalid, i_bready;
    logic [1:0]    o_bresp;
    logic          i_arvalid, o_arready;
    logic [AW-1:0] i_araddr;
    logic          o_rvalid, i_rready;
    logic [DW-1:0] o_rdata;
    logic [1:0]    o_rresp;
    logic          o_mem_req, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [SW-1:0] o_mem_wstrb;
    logic          i_mem_gnt, i_mem_rvalid;
    logic [DW-1:0] i_mem_rdata;

    ysyx_22050710_axil_slave_wrap dut (
        .i_aclk       (clk),
        .i_arst       (i_arst),
        .i_awvalid    (i_awvalid),
        .o_awready    (o_awready),
        .i_awaddr     (i_awaddr),
        .i_awprot     (i_awprot),
        .i_wvalid     (i_wvalid),
        .o_wready     (o_wready),
        .i_wdata      (i_wdata),
        .i_wstrb      (i_wstrb),
        .o_bvalid     (o_bvalid),
        .i_bready     (i_bready),
        .o_bresp      (o_bresp),
        .i_arvalid    (i_arvalid),
        .o_arready    (o_arready),
        .i_araddr     (i_araddr),
        .i_arprot     (i_arprot),
        .o_rvalid     (o_rvalid),
        .i_rready     (i_rready),
        .o_rdata      (o_rdata),
        .o_rresp      (o_rresp),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wstrb  (o_mem_wstrb),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } mem_wr_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [1:0] b_q[$];
    mem_wr_t    mw_q[$];
    logic       grant_log[$];

    int n_checks = 0;
    int n_errors = 0;
    int req_cycles = 0;
    int mem_writes = 0;

    int            rv_delay = 1;
    int            rv_cnt = 0;
    logic [DW-1:0] rv_data = '0;
    logic          ovr_en = 1'b0;
    logic [DW-1:0] ovr_data = '0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {a, a ^ 32'h5A5A_5A5A};
    endfunction

    // Memory model: grants any request in the cycle it appears, returns read
    // data rv_delay cycles after the grant regardless of the DUT's reset.
    initial begin
        mem_wr_t e;
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
        forever begin
            @(negedge clk);
            i_mem_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata  = rv_data;
                end
            end
            if (o_mem_req) req_cycles++;
            if (o_mem_req && !i_arst) begin
                i_mem_gnt = 1'b1;
                grant_log.push_back(!o_mem_we);
                if (o_mem_we) begin
                    mem_writes++;
                    if (mw_q.size() == 0) begin
                        chk("mem_wr_unexpected", mw_q.size(), 1);
                    end else begin
                        e = mw_q.pop_front();
                        chk("mem_wr", {o_mem_addr, o_mem_wdata, o_mem_wstrb}, e);
                    end
                end else begin
                    rv_cnt  = rv_delay;
                    rv_data = ovr_en ? ovr_data : pat(o_mem_addr);
                end
            end else begin
                i_mem_gnt = 1'b0;
            end
        end
    end

    // Response monitor: the handshake seen at the negedge completes at the next posedge.
    initial begin
        rd_exp_t    er;
        logic [1:0] eb;
        forever begin
            @(negedge clk);
            if (o_rvalid && i_rready) begin
                if (rd_q.size() == 0) begin
                    chk("r_unexpected", rd_q.size(), 1);
                end else begin
                    er = rd_q.pop_front();
                    chk("rdata", o_rdata, er.data);
                    chk("rresp", o_rresp, er.resp);
                end
            end
            if (o_bvalid && i_bready) begin
                if (b_q.size() == 0) begin
                    chk("b_unexpected", b_q.size(), 1);
                end else begin
                    eb = b_q.pop_front();
                    chk("bresp", o_bresp, eb);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] ed,
                           input logic [1:0] er, input int exp_lat);
        int n;
        int lat;
        rd_q.push_back('{data: ed, resp: er});
        i_araddr  = a;
        i_arvalid = 1'b1;
        i_rready  = 1'b1;
        n = 0;
        while (!o_arready && n < 50) begin step(); n++; end
        chk("ar_wait", n < 50, 1);
        step();
        i_arvalid = 1'b0;
        lat = 1;
        while (!o_rvalid && lat < 50) begin step(); lat++; end
        chk("r_latency", lat, exp_lat);
        step();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input int gap, input logic [1:0] er, input logic exp_mem);
        int n;
        int lat;
        if (exp_mem) mw_q.push_back('{addr: a, data: d, strb: s});
        b_q.push_back(er);
        i_bready = 1'b1;
        i_wdata  = d;
        i_wstrb  = s;
        i_wvalid = 1'b1;
        n = 0;
        while (!o_wready && n < 50) begin step(); n++; end
        chk("w_wait", n < 50, 1);
        step();
        i_wvalid = 1'b0;
        repeat (gap) step();
        i_awaddr  = a;
        i_awvalid = 1'b1;
        n = 0;
        while (!o_awready && n < 50) begin step(); n++; end
        chk("aw_wait", n < 50, 1);
        step();
        i_awvalid = 1'b0;
        lat = 0;
        while (!o_bvalid && lat < 50) begin step(); lat++; end
        chk("b_latency", lat, exp_mem ? 2 : 1);
        step();
    endtask

    initial begin
        int wc;
        int rc;
        int n;
        i_arst    = 1'b1;
        i_awvalid = 1'b0; i_awaddr = '0; i_awprot = 3'd0;
        i_wvalid  = 1'b0; i_wdata  = '0; i_wstrb  = '0;
        i_bready  = 1'b1;
        i_arvalid = 1'b0; i_araddr = '0; i_arprot = 3'd0;
        i_rready  = 1'b1;
        repeat (3) step();

        chk("rst_arready", o_arready, 0);
        chk("rst_awready", o_awready, 0);
        chk("rst_wready", o_wready, 0);
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_bvalid", o_bvalid, 0);
        chk("rst_mem_req", o_mem_req, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_rresp", o_rresp, 0);
        chk("rst_bresp", o_bresp, 0);
        i_arst = 1'b0;
        #1;
        chk("idle_arready", o_arready, 1);
        chk("idle_awready", o_awready, 1);
        chk("idle_wready", o_wready, 1);
        step();

        // Read hit with a fixed memory word and minimum latency.
        ovr_en   = 1'b1;
        ovr_data = 64'h1122_3344_5566_7788;
        do_read(32'h8000_0010, 64'h1122_3344_5566_7788, 2'b00, 3);
        ovr_en = 1'b0;
        do_read(32'h8000_0100, pat(32'h8000_0100), 2'b00, 3);

        // Write with W two cycles ahead of AW: exactly one memory write.
        wc = mem_writes;
        do_write(32'h8000_0020, 64'hDEAD, 8'h03, 2, 2'b00, 1'b1);
        repeat (4) step();
        chk("single_write", mem_writes - wc, 1);
        do_write(32'h87FF_FFF8, 64'hCAFE_F00D_0123_4567, 8'hFF, 0, 2'b00, 1'b1);

        // Decode misses, including both window edges.
        rc = req_cycles;
        wc = mem_writes;
        do_read(32'h1000_0000, 64'h0, 2'b11, 1);
        do_write(32'h1000_0000, 64'h55, 8'hFF, 0, 2'b11, 1'b0);
        do_read(32'h8800_0000, 64'h0, 2'b11, 1);
        do_read(32'h7FFF_FFF8, 64'h0, 2'b11, 1);
        chk("miss_no_req", req_cycles - rc, 0);
        chk("miss_no_write", mem_writes - wc, 0);
        do_read(32'h87FF_FFF8, pat(32'h87FF_FFF8), 2'b00, 3);

        // Backpressure on R: response held stable, no new read accepted.
        rd_q.push_back('{data: pat(32'h8000_0040), resp: 2'b00});
        i_rready  = 1'b0;
        i_araddr  = 32'h8000_0040;
        i_arvalid = 1'b1;
        n = 0;
        while (!o_arready && n < 50) begin step(); n++; end
        step();
        n = 0;
        while (!o_rvalid && n < 50) begin step(); n++; end
        chk("bp_reach_resp", o_rvalid, 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_rvalid", o_rvalid, 1);
            chk("bp_rdata", o_rdata, pat(32'h8000_0040));
            chk("bp_rresp", o_rresp, 0);
            chk("bp_arready", o_arready, 0);
            step();
        end
        i_arvalid = 1'b0;
        i_rready  = 1'b1;
        step();
        step();

        // Contention after reset: grants must go R, W, R, W.
        i_arst = 1'b1;
        step();
        i_arst = 1'b0;
        grant_log.delete();
        for (int i = 0; i < 2; i++) begin
            rd_q.push_back('{data: pat(32'h8000_0200), resp: 2'b00});
            mw_q.push_back('{addr: 32'h8000_0300, data: 64'hA5A5_0000_FFFF_1234, strb: 8'hF0});
            b_q.push_back(2'b00);
        end
        i_araddr  = 32'h8000_0200;
        i_awaddr  = 32'h8000_0300;
        i_wdata   = 64'hA5A5_0000_FFFF_1234;
        i_wstrb   = 8'hF0;
        i_arvalid = 1'b1;
        i_awvalid = 1'b1;
        i_wvalid  = 1'b1;
        n = 0;
        while (grant_log.size() < 4 && n < 200) begin step(); n++; end
        i_arvalid = 1'b0;
        i_awvalid = 1'b0;
        i_wvalid  = 1'b0;
        chk("grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("grant_order%0d", i), grant_log.size() > i ? grant_log[i] : 1'bx, (i % 2) == 0);
        end
        repeat (5) step();

        // Reset while waiting for read data; the late return must be ignored.
        rv_delay  = 6;
        i_araddr  = 32'h8000_0400;
        i_arvalid = 1'b1;
        n = 0;
        while (!o_arready && n < 50) begin step(); n++; end
        step();
        i_arvalid = 1'b0;
        step();
        i_arst = 1'b1;
        #1;
        chk("rst_forces_arready", o_arready, 0);
        chk("rst_forces_awready", o_awready, 0);
        step();
        i_arst   = 1'b0;
        rv_delay = 1;
        for (int i = 0; i < 10; i++) begin
            chk("abort_rvalid", o_rvalid, 0);
            chk("abort_mem_req", o_mem_req, 0);
            step();
        end
        do_read(32'h8000_0408, pat(32'h8000_0408), 2'b00, 3);

        repeat (5) step();
        chk("rd_q_left", rd_q.size(), 0);
        chk("b_q_left", b_q.size(), 0);
        chk("mw_q_left", mw_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_axil_slave_wrap.md
Name: ysyx_22050710_axil_slave_wrap

Overview:
- AXI-lite responder (slave end) for the core's AXI-lite master ports.
- Accepts AR/AW/W transactions and converts them into requests on a single-port, req/gnt-style memory/device port; returns R/B responses.
- Sits between the AXI-lite interconnect and on-chip SRAM or MMIO models.
- Serialises reads and writes onto one memory port with fair arbitration.

Parameters:
- DATA_WIDTH, 64, data bus width in bits.
- ADDR_WIDTH, 32, address bus width in bits.
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width.
- BASE_ADDR, 32'h8000_0000, first decoded address.
- ADDR_SPAN, 32'h0800_0000, decoded window size in bytes. Hit when BASE_ADDR <= addr < BASE_ADDR+ADDR_SPAN, compared at ADDR_WIDTH+1 bits so the sum cannot wrap.

Ports:
- i_aclk  in  1  clock; all logic on the rising edge.
- i_arst  in  1  reset, synchronous, active-high.
- i_awvalid/o_awready  in/out  1/1  write-address handshake.
- i_awaddr  in  ADDR_WIDTH  write address.
- i_awprot  in  3  write protection (ignored).
- i_wvalid/o_wready  in/out  1/1  write-data handshake.
- i_wdata  in  DATA_WIDTH  write data.
- i_wstrb  in  STRB_WIDTH  byte enables.
- o_bvalid/i_bready  out/in  1/1  write-response handshake.
- o_bresp  out  2  write response (OKAY 2'b00, DECERR 2'b11).
- i_arvalid/o_arready  in/out  1/1  read-address handshake.
- i_araddr  in  ADDR_WIDTH  read address.
- i_arprot  in  3  read protection (ignored).
- o_rvalid/i_rready  out/in  1/1  read-data handshake.
- o_rdata  out  DATA_WIDTH  read data.
- o_rresp  out  2  read response.
- o_mem_req  out  1  memory request; held until i_mem_gnt.
- o_mem_we  out  1  1 = write, 0 = read.
- o_mem_addr  out  ADDR_WIDTH  memory address.
- o_mem_wdata  out  DATA_WIDTH  memory write data.
- o_mem_wstrb  out  STRB_WIDTH  memory byte enables.
- i_mem_gnt  in  1  request accepted; a write completes on gnt.
- i_mem_rvalid  in  1  read data valid; at least 1 cycle after the read gnt.
- i_mem_rdata  in  DATA_WIDTH  read data.

Behaviour:
- Reset (i_arst=1 at the clock edge):
  - state=IDLE; AW/W buffers empty; last_rd=0.
  - All outputs 0: valids, readies, o_mem_req, o_bresp, o_rresp, o_rdata.
  - Readies are also forced to 0 while i_arst is high.
- AW buffer:
  - o_awready = !aw_full.
  - aw_fire captures i_awaddr and sets aw_full.
- W buffer:
  - o_wready = !w_full.
  - w_fire captures i_wdata/i_wstrb and sets w_full.
- AW and W may arrive in either order or in the same cycle.
- Both buffers clear on b_fire. No new write is accepted until the B response is taken.
- wr_pend = aw_full & w_full (write fully captured).
- Arbitration, evaluated in IDLE only:
  - pick_rd = !wr_pend | !last_rd.
  - o_arready = IDLE & pick_rd. It depends only on registers, not on i_arvalid.
  - Reads win a tie after reset. Afterwards reads and writes alternate: last_rd toggles with each granted transaction.
  - ar_fire registers the address and selects the read path.
  - Otherwise, wr_pend selects the write path.
- FSM states: IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_REQ, WR_RESP.
  - IDLE -> RD_REQ on ar_fire with a hit.
  - IDLE -> RD_RESP on ar_fire with a miss: rresp=DECERR, rdata=0, no memory access.
  - IDLE -> WR_REQ on wr_pend with !(i_arvalid & pick_rd) and a hit.
  - IDLE -> WR_RESP on the same write condition with a miss: bresp=DECERR, no memory access.
  - RD_REQ: o_mem_req=1, we=0. Go to RD_WAIT on gnt.
  - RD_WAIT: go to RD_RESP on i_mem_rvalid; capture rdata, rresp=OKAY.
  - RD_RESP: o_rvalid=1, rdata/rresp held stable. Go to IDLE on r_fire.
  - WR_REQ: o_mem_req=1, we=1, addr/wdata/wstrb from the buffers. Go to WR_RESP on gnt; bresp=OKAY.
  - WR_RESP: o_bvalid=1. Go to IDLE on b_fire.
- Minimum latency, read hit with gnt and rvalid 1 cycle later:
  - ar_fire at cycle 0, req at cycle 1, rvalid at cycle 2, o_rvalid at cycle 3.
- Minimum latency, write:
  - Buffers full at cycle 0, req at cycle 1 (gnt same cycle), o_bvalid at cycle 2.
- o_mem_req, o_rvalid and o_bvalid are registered, or decoded directly from the state register.
- Backpressure: rready/bready may stay low indefinitely; data and resp are held stable.
- i_mem_rvalid outside RD_WAIT is ignored, including a stale response arriving after a mid-transaction reset.
- Reset mid-operation: abort immediately. No response is issued for the in-flight transaction; buffers are dropped.
- Address bits below log2(STRB_WIDTH) are passed through unchanged; no alignment check.

Decomposition:
- Response codes (OKAY/EXOKAY/SLVERR/DECERR) belong in the shared axi_defines header as YSYX_22050710_AXI_RESP_* macros. The FSM state encodings stay local.
- One sub-module is natural: ysyx_22050710_axil_chan_buf. It is a single-entry valid/ready holding register (full flag, load on fire, clear input), instantiated for AW and for W.

Test Plan:
- Read hit: ar addr 0x8000_0010, memory returns 0x1122334455667788 one cycle after gnt, rready=1 -> rdata=0x1122334455667788, rresp=00, o_rvalid at cycle 3 after ar_fire.
- Write, W before AW: W wdata=0xDEAD, wstrb=0x03, then AW 0x8000_0020 two cycles later -> a single mem write with those values, then B with bresp=00; no second write.
- Decode miss: read at 0x1000_0000 -> rresp=11, rdata=0, o_mem_req never asserted; a write to the same address gives bresp=11.
- Contention: arvalid and wr_pend both asserted continuously for 4 transactions -> grant order R, W, R, W.
- Backpressure: rready held low for 10 cycles in RD_RESP -> rvalid, rdata and rresp stable; arready=0 throughout.
- Mid-op reset: assert i_arst in RD_WAIT, then deliver a stale i_mem_rvalid -> no o_rvalid; next read completes normally.
